// File: rtl/stripe_pkg.sv
// Shared types and constants for the stripe frame generator.
package stripe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int FVH_F = 2;
    localparam int FVH_V = 1;
    localparam int FVH_H = 0;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;

    function automatic logic signed [11:0] sext_slope(input logic [3:0] s);
        return {{8{s[3]}}, s};
    endfunction

endpackage

// File: rtl/stripe_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used to speckle stripe pixels.
module stripe_lfsr (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    output logic [3:0] nibble
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback_s;

    // Next LFSR state: shift right, feedback into the top bit.
    always_comb begin
        feedback_s = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        if (advance) begin
            lfsr_d = {feedback_s, lfsr_q[15:1]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register, seeded on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign nibble = lfsr_q[3:0];

endmodule

// File: rtl/stripe_frame_gen.sv
// Raster frame generator drawing a sloped white stripe plus per-row expected midpoints.
// Optional pixel speckle noise is compiled in with STRIPE_FRAME_GEN_NOISE_EN.
module stripe_frame_gen
    import stripe_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [9:0] start_col,
    input  logic [3:0] slope,
    input  logic [9:0] stripe_width,
    output logic [2:0] fvh_out,
    output logic       dv_out,
    output logic [7:0] px_out,
    output logic       exp_valid,
    output logic [9:0] exp_row,
    output logic [9:0] exp_midpoint,
    output logic       exp_hit,
    output logic       frame_done
);

    localparam logic [9:0]        H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0]        H_MAX  = 10'(H_ACTIVE + H_BLANK - 1);
    localparam logic [9:0]        V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]        V_MAX  = 10'(V_ACTIVE + V_BLANK - 1);
    localparam logic signed [12:0] H_LAST = 13'(H_ACTIVE - 1);

    state_e            state_q, state_d;
    logic [9:0]        h_q, h_d, v_q, v_d;
    logic signed [11:0] s_q, s_d;
    logic [9:0]        width_q, width_d;
    logic [3:0]        slope_q, slope_d;

    logic run_s, frame_last_s, active_s;
    logic signed [12:0] left_s, right_s, h_pos_s;
    logic [9:0]  lo_s, hi_s, mid_s;
    logic [10:0] mid_sum_s;
    logic        row_hit_s, white_s, speckle_s;

    logic [2:0] fvh_q, fvh_d;
    logic       dv_q, dv_d, exp_valid_q, exp_valid_d, exp_hit_q, exp_hit_d;
    logic       frame_done_q, frame_done_d;
    logic [7:0] px_q, px_d;
    logic [9:0] exp_row_q, exp_row_d, exp_mid_q, exp_mid_d;

    assign run_s        = (state_q == RUN);
    assign frame_last_s = (h_q == H_MAX) && (v_q == V_MAX);
    assign active_s     = (h_q < H_ACT) && (v_q < V_ACT);

    // FSM and raster counters; stripe geometry is latched only at frame start.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        s_d     = s_q;
        width_d = width_q;
        slope_d = slope_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    h_d     = 10'd0;
                    v_d     = 10'd0;
                    s_d     = {2'b00, start_col};
                    width_d = stripe_width;
                    slope_d = slope;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (frame_last_s) begin
                    h_d = 10'd0;
                    v_d = 10'd0;
                    if (enable) begin
                        s_d     = {2'b00, start_col};
                        width_d = stripe_width;
                        slope_d = slope;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (h_q == H_MAX) begin
                    h_d = 10'd0;
                    v_d = v_q + 10'd1;
                    s_d = s_q + sext_slope(slope_q);
                end else begin
                    h_d = h_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stripe bounds at full precision, then clipped to the active line.
    always_comb begin
        left_s    = {s_q[11], s_q};
        right_s   = left_s + $signed({3'b000, width_q}) - 13'sd1;
        h_pos_s   = $signed({3'b000, h_q});
        row_hit_s = (width_q != 10'd0) && (left_s <= H_LAST) && (right_s >= 13'sd0);
        white_s   = (width_q != 10'd0) && (h_pos_s >= left_s) && (h_pos_s <= right_s);
        if (left_s < 13'sd0) begin
            lo_s = 10'd0;
        end else begin
            lo_s = left_s[9:0];
        end
        if (right_s > H_LAST) begin
            hi_s = H_LAST[9:0];
        end else begin
            hi_s = right_s[9:0];
        end
        mid_sum_s = {1'b0, lo_s} + {1'b0, hi_s} + 11'd1;
        mid_s     = 10'(mid_sum_s >> 1);
    end

`ifdef STRIPE_FRAME_GEN_NOISE_EN
    logic [3:0] noise_s;

    stripe_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (run_s),
        .nibble  (noise_s)
    );

    // The first and last visible pixel of a row are never speckled.
    assign speckle_s = (noise_s == 4'h0) && (h_q != lo_s) && (h_q != hi_s);
`else
    assign speckle_s = 1'b0;
`endif

    // Output values for the current counter position; IDLE forces blanking.
    always_comb begin
        fvh_d        = fvh_q;
        dv_d         = 1'b0;
        px_d         = BLACK;
        exp_valid_d  = 1'b0;
        exp_row_d    = exp_row_q;
        exp_mid_d    = exp_mid_q;
        exp_hit_d    = exp_hit_q;
        frame_done_d = 1'b0;
        if (run_s) begin
            if ((h_q == 10'd0) && (v_q == 10'd0)) begin
                fvh_d[FVH_F] = ~fvh_q[FVH_F];
            end else begin
                fvh_d[FVH_F] = fvh_q[FVH_F];
            end
            fvh_d[FVH_V] = (v_q >= V_ACT);
            fvh_d[FVH_H] = (h_q >= H_ACT);
            dv_d         = active_s;
            if (active_s && white_s && !speckle_s) begin
                px_d = WHITE;
            end else begin
                px_d = BLACK;
            end
            if ((h_q == H_ACT) && (v_q < V_ACT)) begin
                exp_valid_d = 1'b1;
                exp_row_d   = v_q;
                exp_hit_d   = row_hit_s;
                if (row_hit_s) begin
                    exp_mid_d = mid_s;
                end else begin
                    exp_mid_d = 10'd0;
                end
            end else begin
                exp_valid_d = 1'b0;
            end
            frame_done_d = frame_last_s;
        end else begin
            fvh_d[FVH_V] = 1'b1;
            fvh_d[FVH_H] = 1'b1;
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            h_q     <= 10'd0;
            v_q     <= 10'd0;
            s_q     <= 12'sd0;
            width_q <= 10'd0;
            slope_q <= 4'd0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            s_q     <= s_d;
            width_q <= width_d;
            slope_q <= slope_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fvh_q        <= 3'b011;
            dv_q         <= 1'b0;
            px_q         <= BLACK;
            exp_valid_q  <= 1'b0;
            exp_row_q    <= 10'd0;
            exp_mid_q    <= 10'd0;
            exp_hit_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fvh_q        <= fvh_d;
            dv_q         <= dv_d;
            px_q         <= px_d;
            exp_valid_q  <= exp_valid_d;
            exp_row_q    <= exp_row_d;
            exp_mid_q    <= exp_mid_d;
            exp_hit_q    <= exp_hit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fvh_out      = fvh_q;
    assign dv_out       = dv_q;
    assign px_out       = px_q;
    assign exp_valid    = exp_valid_q;
    assign exp_row      = exp_row_q;
    assign exp_midpoint = exp_mid_q;
    assign exp_hit      = exp_hit_q;
    assign frame_done   = frame_done_q;

endmodule
